// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_hazard_check.sv
// Register-match compare of N source registers against a reference,
// masked so register 0 never matches.
module hazard_check
  import regfile_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [REG_W-1:0]        ref_reg,
  input  logic [N-1:0][REG_W-1:0] srcs,
  output logic [N-1:0]            hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (ref_reg != REG_ZERO) && (srcs[i] == ref_reg);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between pipeline writeback and the
// multdiv unit, tracks the outstanding multdiv destination and provides bypass.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_reg,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_data,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_is_md,
  output logic              id_stall,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              byp_a_en,
  output logic              byp_b_en,
  output logic [DATA_W-1:0] byp_data,
  output logic              err_protocol
);

  state_t              state;
  logic [REG_W-1:0]    pend_reg;
  logic [DATA_W-1:0]   buf_data;
  logic [CNT_W-1:0]    wait_cnt;

  logic                run;
  logic                force_drain;
  logic                hold_drain;
  logic                direct_md;
  logic                sel_vld;
  logic [REG_W-1:0]    sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [2:0]          haz_hit;
  logic [1:0]          byp_hit;

  // Outputs are forced low for the whole time reset is asserted.
  assign run         = !ctrl_reset;
  assign force_drain = (state == HOLD) && (wait_cnt == CNT_W'(MAX_WAIT));
  assign hold_drain  = (state == HOLD) && (!wb_valid || force_drain);
  assign direct_md   = (state == BUSY) && md_done && !wb_valid;

  always_comb begin
    sel_vld  = 1'b0;
    sel_reg  = REG_ZERO;
    sel_data = '0;
    if (hold_drain || direct_md) begin
      sel_vld  = 1'b1;
      sel_reg  = pend_reg;
      sel_data = hold_drain ? buf_data : md_data;
    end else if (wb_valid) begin
      sel_vld  = 1'b1;
      sel_reg  = wb_reg;
      sel_data = wb_data;
    end
  end

  assign ctrl_writeEnable = run && sel_vld && (sel_reg != REG_ZERO);
  assign ctrl_writeReg    = run ? sel_reg : REG_ZERO;
  assign data_writeReg    = run ? sel_data : '0;
  assign byp_data         = data_writeReg;
  assign wb_stall         = run && force_drain;

  hazard_check #(.N(3)) u_hazard (
    .ref_reg (pend_reg),
    .srcs    ({id_rd, id_rt, id_rs}),
    .hit     (haz_hit)
  );

  hazard_check #(.N(2)) u_bypass (
    .ref_reg (ctrl_writeReg),
    .srcs    ({id_rt, id_rs}),
    .hit     (byp_hit)
  );

  assign byp_a_en = ctrl_writeEnable && byp_hit[0];
  assign byp_b_en = ctrl_writeEnable && byp_hit[1];

  assign id_stall = run && (((state != IDLE) && ((|haz_hit) || id_is_md)) || force_drain);

  // Offending multdiv handshakes only raise the sticky flag; they never change state.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state        <= IDLE;
      pend_reg     <= REG_ZERO;
      buf_data     <= '0;
      wait_cnt     <= '0;
      err_protocol <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_issue) begin
            state    <= BUSY;
            pend_reg <= md_issue_reg;
          end
          if (md_done) err_protocol <= 1'b1;
        end
        BUSY: begin
          if (md_done) begin
            if (wb_valid) begin
              buf_data <= md_data;
              wait_cnt <= '0;
              state    <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
          if (md_issue) err_protocol <= 1'b1;
        end
        HOLD: begin
          if (md_issue || md_done) err_protocol <= 1'b1;
          if (force_drain || !wb_valid) state <= IDLE;
          else wait_cnt <= wait_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
